element_ram_arbiter: RTL and testbench
======================================

# element_ram_arbiter

Two-requester arbiter for the single-port element RAM (32 x 32-bit). Port A is the element-entry stage, which writes parsed elements. Port B is the downstream analysis stage, which reads and writes elements. The arbiter grants the RAM to one port at a time, muxes that port's address, data and write-enable onto the RAM, and routes read-data-valid back to the port that issued each read. It sits between the stage datapaths and the RAM instance, so stages can overlap without corrupting RAM traffic.

## Interface
- ADDR_W, 5, element RAM address width
- DATA_W, 32, element word width
- MAX_BURST, 16, max consecutive accesses by one owner while the other port waits (>=2)

- clk  in  1  system clock
- program_reset  in  1  asynchronous, active-high reset
- a_req / b_req  in  1  port requests RAM ownership; held high for the whole burst
- a_addr / b_addr  in  ADDR_W  access address
- a_data / b_data  in  DATA_W  write data
- a_wren / b_wren  in  1  access is a write (else a read)
- a_grant / b_grant  out  1  registered ownership flag
- a_rvalid / b_rvalid  out  1  rdata holds this port's read result this cycle
- rdata  out  DATA_W  shared read data, passed through from element_q
- element_q  in  DATA_W  RAM output (address registered in RAM, unregistered q)
- element_addr  out  ADDR_W  RAM address
- element_data  out  DATA_W  RAM write data
- element_wren  out  1  RAM write enable
- busy  out  1  either grant high

## Operation
- States: IDLE, GNT_A, GNT_B. a_grant = (state==GNT_A); b_grant = (state==GNT_B).
- Access: occurs in any cycle with X_grant && X_req. element_addr and element_data come from the owner (port A in IDLE). element_wren = X_grant & X_req & X_wren (combinational). It is never high without a grant.
- IDLE: only A requesting -> GNT_A. Only B requesting -> GNT_B. Both requesting -> priority pick (see Configuration).
- GNT_X with X_req low: if the other port requests, go to GNT_other; else go to IDLE. There is no dead cycle on handover.
- Burst counter: cleared on every grant change. Increments on each access by the owner and saturates at MAX_BURST.
- Forced release: when the counter reaches MAX_BURST and the other port's req is high, the next state is GNT_other, even if the owner still requests. The preempted owner re-wins through normal arbitration.
- Reads: a read access at cycle t sets X_rvalid in cycle t+1 (one-cycle pulse per read). Port tag is registered, so a read completes correctly even if ownership changes at t+1.
- rdata = element_q at all times. It is meaningful only with an rvalid.
- Reset values: state IDLE, both grants 0, both rvalids 0, burst counter 0, last_owner = B, busy 0. element_wren is 0 while reset is asserted.
- Reset mid-burst: grants drop asynchronously and any in-flight rvalid is discarded.

## Timing
- Request to grant: req rising at edge t gives grant high after edge t+1. The earliest access is in cycle t+1.
- Owner req falling at edge t gives grant low after edge t+1. Any handover grant rises at that same edge.
- Throughput: one access per cycle while granted.
- A cycle with grant high and req low performs no access.

## Configuration
- ELEMENT_RAM_RR_EN defined: round-robin. On a simultaneous request from IDLE, the port that is not last_owner wins. last_owner updates on every grant. Port A wins the first contest after reset.
- ELEMENT_RAM_RR_EN undefined: fixed priority, A always wins a simultaneous request from IDLE. last_owner logic is not built. Forced release via MAX_BURST remains active in both modes.

## Structure
- Shared package element_ram_pkg holds:
  - ADDR_W and DATA_W defaults
  - state encoding (IDLE=2'd0, GNT_A=2'd1, GNT_B=2'd2)
  - port-id constants PORT_A=1'b0, PORT_B=1'b1
- One sub-module, element_ram_burst_counter: clear, increment and saturate at MAX_BURST, with a `limit` output. Everything else stays in the arbiter.

## Test plan
- Reset: assert program_reset mid-cycle -> grants, rvalids and element_wren go to 0 immediately. State returns to IDLE.
- Single writer: A writes 0xDEADBEEF to addr 3 with b_req=0 -> a_grant one cycle after a_req. element_wren=1 with addr 3 for exactly one cycle.
- Read return: B reads addr 3 -> b_rvalid in the next cycle, rdata=0xDEADBEEF, a_rvalid stays 0.
- Simultaneous request from IDLE:
  - RR build: A wins first, B wins on the next contest.
  - Fixed build: A wins both.
- Burst limit: MAX_BURST=4, A streams writes, B requests -> after A's 4th access b_grant rises the next cycle with no A write leaking. A regains the grant after B drops b_req.
- Handover read: B reads at the last cycle of ownership while A takes over -> b_rvalid pulses once, correct data, a_rvalid=0 that cycle.

Source files
------------

// File: rtl/element_ram_pkg.sv
// Shared types and constants for the element RAM arbiter.
package element_ram_pkg;

  localparam int unsigned ELEM_ADDR_W = 5;
  localparam int unsigned ELEM_DATA_W = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntA = 2'd1,
    StGntB = 2'd2
  } arb_state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/element_ram_arbiter_if.sv
// One requester's view of the element RAM arbiter; rdata is the shared RAM output.
interface element_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic              grant;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, data, wren, input grant, rvalid, rdata);
  modport slave  (input req, addr, data, wren, output grant, rvalid, rdata);
endinterface

// File: rtl/element_ram_burst_counter.sv
// Counts owner accesses since the last grant change, saturating at MAX_BURST.
module element_ram_burst_counter #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic clk,
  input  logic program_reset,
  input  logic clear,
  input  logic inc,
  output logic limit
);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);
  localparam logic [CntW-1:0] PreMax = CntW'(MAX_BURST - 1);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk or posedge program_reset) begin
    if (program_reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != MaxCnt)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Includes the access in flight so the owner is stopped right after its last allowed access.
  assign limit = (count_q == MaxCnt) || (inc && (count_q == PreMax));

endmodule

// File: rtl/element_ram_arbiter.sv
// Two-port arbiter for the single-port element RAM.
// Define ELEMENT_RAM_RR_EN for round-robin contests from idle; otherwise port A has priority.
module element_ram_arbiter
  import element_ram_pkg::*;
#(
  parameter int unsigned ADDR_W    = ELEM_ADDR_W,
  parameter int unsigned DATA_W    = ELEM_DATA_W,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              program_reset,
  element_ram_arbiter_if.slave a_port,
  element_ram_arbiter_if.slave b_port,
  input  logic [DATA_W-1:0] element_q,
  output logic [ADDR_W-1:0] element_addr,
  output logic [DATA_W-1:0] element_data,
  output logic              element_wren,
  output logic              busy
);
  arb_state_e state_q, state_d;
  logic a_grant_q, b_grant_q, a_rvalid_q, b_rvalid_q;
  logic a_acc, b_acc, limit, pick_b;

  assign a_acc = a_grant_q & a_port.req;
  assign b_acc = b_grant_q & b_port.req;

`ifdef ELEMENT_RAM_RR_EN
  logic last_owner_q;

  always_ff @(posedge clk or posedge program_reset) begin
    if (program_reset) begin
      last_owner_q <= PORT_B;
    end else if (state_d == StGntA) begin
      last_owner_q <= PORT_A;
    end else if (state_d == StGntB) begin
      last_owner_q <= PORT_B;
    end
  end

  assign pick_b = (last_owner_q == PORT_A);
`else
  assign pick_b = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (a_port.req && b_port.req) state_d = pick_b ? StGntB : StGntA;
        else if (a_port.req)          state_d = StGntA;
        else if (b_port.req)          state_d = StGntB;
      end
      StGntA: begin
        if (!a_port.req || (limit && b_port.req)) state_d = b_port.req ? StGntB : StIdle;
      end
      StGntB: begin
        if (!b_port.req || (limit && a_port.req)) state_d = a_port.req ? StGntA : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  element_ram_burst_counter #(
    .MAX_BURST(MAX_BURST)
  ) u_burst_counter (
    .clk          (clk),
    .program_reset(program_reset),
    .clear        (state_d != state_q),
    .inc          (a_acc | b_acc),
    .limit        (limit)
  );

  // Read tags are registered per port so a read completes even across a handover.
  always_ff @(posedge clk or posedge program_reset) begin
    if (program_reset) begin
      state_q    <= StIdle;
      a_grant_q  <= 1'b0;
      b_grant_q  <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_grant_q  <= (state_d == StGntA);
      b_grant_q  <= (state_d == StGntB);
      a_rvalid_q <= a_acc & ~a_port.wren;
      b_rvalid_q <= b_acc & ~b_port.wren;
    end
  end

  assign a_port.grant  = a_grant_q;
  assign b_port.grant  = b_grant_q;
  assign a_port.rvalid = a_rvalid_q;
  assign b_port.rvalid = b_rvalid_q;
  assign a_port.rdata  = element_q;
  assign b_port.rdata  = element_q;

  assign element_addr = b_grant_q ? b_port.addr : a_port.addr;
  assign element_data = b_grant_q ? b_port.data : a_port.data;
  assign element_wren = (a_acc & a_port.wren) | (b_acc & b_port.wren);
  assign busy         = a_grant_q | b_grant_q;

endmodule

// File: tb/tb_element_ram_arbiter.sv
// Directed bench for element_ram_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_element_ram_arbiter;
  import element_ram_pkg::*;

  logic        clk = 1'b0;
  logic        program_reset;
  logic [31:0] element_q;
  logic [4:0]  element_addr;
  logic [31:0] element_data;
  logic        element_wren;
  logic        busy;

  element_ram_arbiter_if #(.ADDR_W(5), .DATA_W(32)) a_if ();
  element_ram_arbiter_if #(.ADDR_W(5), .DATA_W(32)) b_if ();

  element_ram_arbiter #(
    .ADDR_W   (5),
    .DATA_W   (32),
    .MAX_BURST(4)
  ) dut (
    .clk          (clk),
    .program_reset(program_reset),
    .a_port       (a_if.slave),
    .b_port       (b_if.slave),
    .element_q    (element_q),
    .element_addr (element_addr),
    .element_data (element_data),
    .element_wren (element_wren),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // RAM: registered address, unregistered output.
  logic [31:0] mem [32];
  logic [4:0]  ram_addr_q;
  always @(posedge clk) begin
    if (element_wren) mem[element_addr] <= element_data;
    ram_addr_q <= element_addr;
  end
  assign element_q = mem[ram_addr_q];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] shadow [32];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_check();
    logic ea, eb;
    logic [31:0] ed;
    ea = 1'b0; eb = 1'b0; ed = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      ea = (sb[0].port == PORT_A);
      eb = !ea;
      ed = sb[0].data;
    end
    chk("a_rvalid", {31'd0, a_if.rvalid}, {31'd0, ea});
    chk("b_rvalid", {31'd0, b_if.rvalid}, {31'd0, eb});
    if (ea || eb) begin
      chk("rdata", a_if.rdata, ed);
      void'(sb.pop_front());
    end
  endtask

  task automatic neg();
    @(negedge clk);
    sb_check();
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic port, input logic [4:0] addr);
    exp_t e;
    e.port = port;
    e.data = shadow[addr];
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drive_a(input logic req, input logic wren, input logic [4:0] addr,
                         input logic [31:0] data);
    a_if.req = req; a_if.wren = wren; a_if.addr = addr; a_if.data = data;
  endtask

  task automatic drive_b(input logic req, input logic wren, input logic [4:0] addr,
                         input logic [31:0] data);
    b_if.req = req; b_if.wren = wren; b_if.addr = addr; b_if.data = data;
  endtask

  logic win2_b;

  initial begin
`ifdef ELEMENT_RAM_RR_EN
    win2_b = 1'b1;
`else
    win2_b = 1'b0;
`endif
    program_reset = 1'b1;
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    neg();
    chk("reset a_grant", {31'd0, a_if.grant}, 0);
    chk("reset b_grant", {31'd0, b_if.grant}, 0);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset wren", {31'd0, element_wren}, 0);
    pos();
    program_reset = 1'b0;

    // Single writer.
    drive_a(1, 1, 3, 32'hDEADBEEF);
    neg();
    chk("a_grant before", {31'd0, a_if.grant}, 0);
    chk("wren before grant", {31'd0, element_wren}, 0);
    pos();
    neg();
    chk("a_grant", {31'd0, a_if.grant}, 1);
    chk("busy", {31'd0, busy}, 1);
    chk("write wren", {31'd0, element_wren}, 1);
    chk("write addr", {27'd0, element_addr}, 3);
    chk("write data", element_data, 32'hDEADBEEF);
    shadow[3] = 32'hDEADBEEF;
    pos();
    drive_a(0, 0, 0, 0);
    neg();
    chk("grant w/o req still held", {31'd0, a_if.grant}, 1);
    chk("no access w/o req", {31'd0, element_wren}, 0);
    pos();

    // Read return to B.
    drive_b(1, 0, 3, 0);
    neg();
    chk("a_grant released", {31'd0, a_if.grant}, 0);
    chk("b_grant before", {31'd0, b_if.grant}, 0);
    pos();
    neg();
    chk("b_grant", {31'd0, b_if.grant}, 1);
    chk("read wren", {31'd0, element_wren}, 0);
    rd(PORT_B, 3);
    pos();
    drive_b(0, 0, 0, 0);
    neg();
    pos();

    // Two simultaneous contests from idle.
    drive_a(1, 0, 3, 0);
    drive_b(1, 0, 3, 0);
    neg();
    chk("idle before contest", {31'd0, busy}, 0);
    pos();
    neg();
    chk("contest1 a_grant", {31'd0, a_if.grant}, 1);
    chk("contest1 b_grant", {31'd0, b_if.grant}, 0);
    rd(PORT_A, 3);
    pos();
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    neg();
    pos();
    drive_a(1, 0, 3, 0);
    drive_b(1, 0, 3, 0);
    neg();
    chk("idle before contest2", {31'd0, busy}, 0);
    pos();
    neg();
    chk("contest2 a_grant", {31'd0, a_if.grant}, {31'd0, !win2_b});
    chk("contest2 b_grant", {31'd0, b_if.grant}, {31'd0, win2_b});
    rd(win2_b ? PORT_B : PORT_A, 3);
    pos();
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    neg();
    pos();

    // Burst limit: A streams four writes while B waits.
    drive_a(1, 1, 10, 32'hA000_0000);
    neg();
    pos();
    for (int k = 0; k < 4; k++) begin
      drive_a(1, 1, 5'(10 + k), 32'hA000_0000 + k);
      if (k == 1) drive_b(1, 0, 10, 0);
      neg();
      chk("burst a_grant", {31'd0, a_if.grant}, 1);
      chk("burst b_grant", {31'd0, b_if.grant}, 0);
      chk("burst wren", {31'd0, element_wren}, 1);
      chk("burst addr", {27'd0, element_addr}, 32'(10 + k));
      shadow[10 + k] = 32'hA000_0000 + k;
      pos();
    end
    drive_a(1, 1, 14, 32'hA000_0004);
    neg();
    chk("preempt b_grant", {31'd0, b_if.grant}, 1);
    chk("preempt a_grant", {31'd0, a_if.grant}, 0);
    chk("no A leak wren", {31'd0, element_wren}, 0);
    chk("B addr muxed", {27'd0, element_addr}, 10);
    rd(PORT_B, 10);
    pos();
    drive_b(0, 0, 0, 0);
    neg();
    chk("b held w/o req", {31'd0, b_if.grant}, 1);
    pos();
    neg();
    chk("A regains", {31'd0, a_if.grant}, 1);
    chk("B released", {31'd0, b_if.grant}, 0);
    chk("A resumes write", {31'd0, element_wren}, 1);
    chk("A resume addr", {27'd0, element_addr}, 14);
    shadow[14] = 32'hA000_0004;
    pos();

    // Handover read: B's last read lands while A already owns the RAM.
    drive_a(0, 0, 0, 0);
    drive_b(1, 0, 10, 0);
    neg();
    chk("A idle owner", {31'd0, a_if.grant}, 1);
    pos();
    for (int j = 0; j < 4; j++) begin
      drive_b(1, 0, 5'(10 + j), 0);
      if (j == 0) drive_a(1, 1, 20, 32'h5A5A_0020);
      neg();
      chk("B burst grant", {31'd0, b_if.grant}, 1);
      rd(PORT_B, 5'(10 + j));
      pos();
    end
    neg();
    chk("handover a_grant", {31'd0, a_if.grant}, 1);
    chk("handover b_grant", {31'd0, b_if.grant}, 0);
    chk("handover A write", {31'd0, element_wren}, 1);
    chk("handover addr", {27'd0, element_addr}, 20);
    shadow[20] = 32'h5A5A_0020;
    pos();

    // Mid-cycle reset with a write in progress and a read return pending.
    drive_b(0, 0, 0, 0);
    drive_a(1, 0, 3, 0);
    neg();
    chk("A keeps grant", {31'd0, a_if.grant}, 1);
    pos();
    drive_a(1, 1, 5, 32'h0000_1234);
    chk("pending a_rvalid", {31'd0, a_if.rvalid}, 1);
    #1;
    chk("pre-reset wren", {31'd0, element_wren}, 1);
    #1;
    program_reset = 1'b1;
    #1;
    chk("async a_grant", {31'd0, a_if.grant}, 0);
    chk("async a_rvalid", {31'd0, a_if.rvalid}, 0);
    chk("async wren", {31'd0, element_wren}, 0);
    chk("async busy", {31'd0, busy}, 0);
    neg();
    pos();
    program_reset = 1'b0;
    neg();
    chk("post-reset idle", {31'd0, a_if.grant}, 0);
    pos();
    neg();
    chk("post-reset regrant", {31'd0, a_if.grant}, 1);
    pos();
    drive_a(0, 0, 0, 0);
    neg();
    pos();
    neg();
    chk("scoreboard drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
